modmul_barrett_pipe: RTL and testbench

- Pipelined modular multiplier for Kyber (q = 3329): computes c = a*b mod q using Barrett reduction.
- Sits directly upstream of modadd in the NTT butterfly. It produces the twiddle product w*b that modadd combines with a.
- Uses a valid/ready stream with a global stall so the butterfly can back-pressure it.
- Carries a sideband tag so downstream stages can realign coefficient indices.

---
 rtl/modmul_barrett_pipe.sv | 120 ++++++++++++
 tb/tb_modmul_barrett_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/modmul_barrett_pipe.sv
// Four-stage Barrett modular multiplier (c = a*b mod q) with valid/ready and a global stall.
// Define MODMUL_RANGE_CHECK_EN to add the pipelined range_err flag for operands >= Q_VALUE.
module modmul_barrett_pipe #(
  parameter int              LOGQ      = 12,
  parameter logic [LOGQ:0]   Q_VALUE   = 13'd3329,
  parameter int              BARRETT_K = 24,
  parameter int              BARRETT_M = 5039,
  parameter int              TAG_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOGQ-1:0]  a,
  input  logic [LOGQ-1:0]  b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOGQ-1:0]  c,
  output logic [TAG_W-1:0] out_tag
`ifdef MODMUL_RANGE_CHECK_EN
  ,
  output logic             range_err
`endif
);

  localparam int PW = 2 * LOGQ;
  localparam int MW = 2 * LOGQ + 13;
  localparam int RW = LOGQ + 2;

  logic             adv;

  logic             s1_valid, s2_valid, s3_valid, s4_valid;
  logic [TAG_W-1:0] s1_tag, s2_tag, s3_tag, s4_tag;
  logic [PW-1:0]    s1_p, s2_p;
  logic [LOGQ:0]    s2_t;
  logic [RW-1:0]    s3_r;
  logic [LOGQ-1:0]  s4_c;

  logic [PW-1:0]    p_next;
  logic [LOGQ:0]    t_next;
  logic [RW-1:0]    r_next;
  logic [RW-1:0]    r_red;
  logic [LOGQ-1:0]  c_next;

  assign adv      = !s4_valid || out_ready;
  assign in_ready = adv;

  assign p_next = PW'(a) * PW'(b);

  // Full-width product before the shift; only the quotient estimate is kept.
  assign t_next = (LOGQ+1)'((MW'(s1_p) * MW'(BARRETT_M)) >> BARRETT_K);

  // True remainder is below 3q, so modular arithmetic in RW bits is exact.
  assign r_next = RW'(s2_p) - RW'(RW'(s2_t) * RW'(Q_VALUE));

  always_comb begin
    r_red = s3_r;
    if (r_red >= RW'(Q_VALUE)) r_red = r_red - RW'(Q_VALUE);
    if (r_red >= RW'(Q_VALUE)) r_red = r_red - RW'(Q_VALUE);
    c_next = LOGQ'(r_red);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s4_valid <= 1'b0;
      s1_tag   <= '0;
      s2_tag   <= '0;
      s3_tag   <= '0;
      s4_tag   <= '0;
      s1_p     <= '0;
      s2_p     <= '0;
      s2_t     <= '0;
      s3_r     <= '0;
      s4_c     <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      s4_valid <= s3_valid;
      s1_tag   <= in_tag;
      s2_tag   <= s1_tag;
      s3_tag   <= s2_tag;
      s4_tag   <= s3_tag;
      s1_p     <= p_next;
      s2_p     <= s1_p;
      s2_t     <= t_next;
      s3_r     <= r_next;
      s4_c     <= c_next;
    end
  end

  assign out_valid = s4_valid;
  assign c         = s4_c;
  assign out_tag   = s4_tag;

`ifdef MODMUL_RANGE_CHECK_EN
  logic s1_err, s2_err, s3_err, s4_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_err <= 1'b0;
      s2_err <= 1'b0;
      s3_err <= 1'b0;
      s4_err <= 1'b0;
    end else if (adv) begin
      s1_err <= ({1'b0, a} >= Q_VALUE) || ({1'b0, b} >= Q_VALUE);
      s2_err <= s1_err;
      s3_err <= s2_err;
      s4_err <= s3_err;
    end
  end

  assign range_err = s4_err;
`endif

endmodule

// File: tb/tb_modmul_barrett_pipe.sv
// Directed and scoreboarded bench for modmul_barrett_pipe: latency, ordering, stall hold, reset flush.
// Define MODMUL_RANGE_CHECK_EN to also exercise range_err.
module tb_modmul_barrett_pipe;

  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] a, b;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] c;
  logic [7:0]  out_tag;
`ifdef MODMUL_RANGE_CHECK_EN
  logic        range_err;
`endif

  modmul_barrett_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .out_tag   (out_tag)
`ifdef MODMUL_RANGE_CHECK_EN
    ,
    .range_err (range_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int c;
    int tag;
    int err;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_c_drv = 0;
  int   exp_err_drv = 0;
  bit   lat_mode = 1'b0;
  bit   rand_rdy = 1'b0;
  bit   hold_v = 1'b0;
  logic [11:0] hold_c;
  logic [7:0]  hold_tag;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor samples on the falling edge; inputs only change just after rising edges.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("c", c, e.c);
          chk("out_tag", out_tag, e.tag);
`ifdef MODMUL_RANGE_CHECK_EN
          chk("range_err", range_err, e.err);
`endif
          if (lat_mode) chk("latency", cyc - e.cyc, 4);
        end
      end
      if (out_valid && !out_ready) begin
        chk("in_ready_stall", in_ready, 0);
        if (hold_v) begin
          chk("hold_c", c, hold_c);
          chk("hold_tag", out_tag, hold_tag);
        end
        hold_v   = 1'b1;
        hold_c   = c;
        hold_tag = out_tag;
      end else begin
        hold_v = 1'b0;
      end
      if (in_valid && in_ready) sb.push_back('{exp_c_drv, int'(in_tag), exp_err_drv, cyc});
    end
  end

  // Presents one operand pair and returns just after the edge that accepted it.
  task automatic send(input int av, input int bv, input int tg, input int ec, input int er);
    int n;
    a           = 12'(av);
    b           = 12'(bv);
    in_tag      = 8'(tg);
    exp_c_drv   = ec;
    exp_err_drv = er;
    in_valid    = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 200) chk("send_timeout", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    if (n == 200) chk("drain_timeout", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  int b2b_a[4] = '{3328, 17, 0, 3328};
  int b2b_b[4] = '{3328, 196, 3000, 1};
  int b2b_c[4] = '{1, 3, 0, 3328};

  int st_a[10] = '{1234, 1000, 3000, 2, 3328, 0, 3328, 1, 100, 2000};
  int st_b[10] = '{2345, 1000, 3000, 1665, 2, 0, 0, 1, 100, 3};
  int st_c[10] = '{829, 1300, 1713, 1, 3327, 0, 0, 1, 13, 2671};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int av, bv;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_c", c, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef MODMUL_RANGE_CHECK_EN
    chk("rst_range_err", range_err, 0);
`endif
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single transaction, fixed latency.
    lat_mode = 1'b1;
    send(1234, 2345, 'h5A, 829, 0);
    drain();

    // Back-to-back, boundary operands.
    for (int i = 0; i < 4; i++) send(b2b_a[i], b2b_b[i], 'h10 + i, b2b_c[i], 0);
    drain();

    // Ten items with a three-cycle downstream stall mid-stream.
    lat_mode = 1'b0;
    fork
      for (int i = 0; i < 10; i++) send(st_a[i], st_b[i], 'h20 + i, st_c[i], 0);
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Random operands with random bubbles and back-pressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      av = $urandom_range(0, Q - 1);
      bv = $urandom_range(0, Q - 1);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      send(av, bv, i & 'hFF, (av * bv) % Q, 0);
    end
    in_valid  = 1'b0;
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with three items in flight discards them.
    lat_mode = 1'b1;
    send(100, 100, 'h41, 13, 0);
    send(2, 1665, 'h42, 1, 0);
    send(17, 196, 'h43, 3, 0);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_c", c, 0);
    chk("midrst_out_tag", out_tag, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_idle", out_valid, 0);
    send(1000, 1000, 'h33, 1300, 0);
    drain();

`ifdef MODMUL_RANGE_CHECK_EN
    send(4095, 2, 'h61, 1532, 1);
    send(5, 6, 'h62, 30, 0);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
